// File: rtl/cv32e40p_tb_subsys.sv
// -----------------------------------------------------------------------------
// cv32e40p_tb_subsys
//   Simulation subsystem for a CV32E40P-style core. It provides program memory
//   and testbench MMIO. Two OBI-style ports (instruction fetch, data) share one
//   dual-port little-endian byte RAM at ram_i.dp_ram_i.mem. Data-port stores to
//   fixed MMIO addresses raise pass / fail / exit / stdout events.
//
//   Ports:
//     clk_i, rst_i                      clock, async active-high reset
//     fetch_enable_i -> core_fetch_enable_o   combinational pass-through
//     boot_addr_o, dm_halt_addr_o       constants BOOT_ADDR / DM_HALTADDRESS
//     instr_req/addr_i, instr_gnt/rvalid/rdata_o        fetch port
//     data_req/addr/we/be/wdata_i, data_gnt/rvalid/rdata_o  data port
//     tests_passed_o, tests_failed_o    one-cycle pulses (tohost 0x2000_0000)
//     exit_valid_o, exit_value_o        exit pulse + held code (0x2000_0004)
//     stdout_valid_o, stdout_char_o     char pulse + held char (0x1000_0000)
//
//   Handshake: gnt = req on both ports (never stalls). A request is accepted
//   when req && gnt; rvalid and rdata follow exactly one cycle later.
//
//   Optional: define STDOUT_PRINT_EN to also $write each stdout character.
// -----------------------------------------------------------------------------

// Byte RAM: combinational word read on port A and B, byte-masked write on B.
// Reads see the array before any write of the same edge, so a same-word
// collision returns the old value once registered by the top.
module cv32e40p_tb_subsys_dp_ram #(
    parameter int ADDR_WIDTH = 22
) (
    input  logic                  clk_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    output logic [31:0]           a_word_o,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic                  b_we_i,
    input  logic [3:0]            b_be_i,
    input  logic [31:0]           b_wdata_i,
    output logic [31:0]           b_word_o
);
    logic [7:0] mem [2**ADDR_WIDTH];

    always_comb begin
        a_word_o = {mem[{a_addr_i[ADDR_WIDTH-1:2], 2'd3}], mem[{a_addr_i[ADDR_WIDTH-1:2], 2'd2}],
                    mem[{a_addr_i[ADDR_WIDTH-1:2], 2'd1}], mem[{a_addr_i[ADDR_WIDTH-1:2], 2'd0}]};
        b_word_o = {mem[{b_addr_i[ADDR_WIDTH-1:2], 2'd3}], mem[{b_addr_i[ADDR_WIDTH-1:2], 2'd2}],
                    mem[{b_addr_i[ADDR_WIDTH-1:2], 2'd1}], mem[{b_addr_i[ADDR_WIDTH-1:2], 2'd0}]};
    end

    // Contents survive reset; only the byte lanes enabled by b_be_i change.
    always_ff @(posedge clk_i) begin
        if (b_we_i) begin
            if (b_be_i[0]) mem[{b_addr_i[ADDR_WIDTH-1:2], 2'd0}] <= b_wdata_i[7:0];
            if (b_be_i[1]) mem[{b_addr_i[ADDR_WIDTH-1:2], 2'd1}] <= b_wdata_i[15:8];
            if (b_be_i[2]) mem[{b_addr_i[ADDR_WIDTH-1:2], 2'd2}] <= b_wdata_i[23:16];
            if (b_be_i[3]) mem[{b_addr_i[ADDR_WIDTH-1:2], 2'd3}] <= b_wdata_i[31:24];
        end
    end
endmodule

// Wrapper that gives the array its well-known hierarchical path.
module cv32e40p_tb_subsys_ram #(
    parameter int ADDR_WIDTH = 22
) (
    input  logic                  clk_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic [31:0]           instr_word_o,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic [31:0]           data_word_o
);
    cv32e40p_tb_subsys_dp_ram #(.ADDR_WIDTH(ADDR_WIDTH)) dp_ram_i (
        .clk_i     (clk_i),
        .a_addr_i  (instr_addr_i),
        .a_word_o  (instr_word_o),
        .b_addr_i  (data_addr_i),
        .b_we_i    (data_we_i),
        .b_be_i    (data_be_i),
        .b_wdata_i (data_wdata_i),
        .b_word_o  (data_word_o)
    );
endmodule

module cv32e40p_tb_subsys #(
    parameter int          INSTR_RDATA_WIDTH = 32,
    parameter int          RAM_ADDR_WIDTH    = 22,
    parameter logic [31:0] BOOT_ADDR         = 32'h180,
    parameter logic [31:0] DM_HALTADDRESS    = 32'h1A110800
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_enable_i,
    output logic        core_fetch_enable_o,
    output logic [31:0] boot_addr_o,
    output logic [31:0] dm_halt_addr_o,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o,
    output logic        stdout_valid_o,
    output logic [7:0]  stdout_char_o
);
    generate
        if (INSTR_RDATA_WIDTH != 32) begin : g_bad_width
            $fatal(1, "cv32e40p_tb_subsys: INSTR_RDATA_WIDTH must be 32");
        end
    endgenerate

    localparam logic [31:0] ADDR_STDOUT = 32'h1000_0000;
    localparam logic [31:0] ADDR_TOHOST = 32'h2000_0000;
    localparam logic [31:0] ADDR_EXIT   = 32'h2000_0004;
    localparam logic [31:0] TOHOST_PASS = 32'd123456789;
    localparam logic [31:0] TOHOST_FAIL = 32'd1;

    logic [RAM_ADDR_WIDTH-1:0] instr_idx, data_idx;
    logic [31:0] instr_word, data_word;
    logic is_stdout, is_tohost, is_exit, is_mmio, data_wr, ram_we;
    logic unused_addr_bits;

    logic        instr_rvalid_d, instr_rvalid_q, data_rvalid_d, data_rvalid_q;
    logic [31:0] instr_rdata_d, instr_rdata_q, data_rdata_d, data_rdata_q;
    logic        tests_passed_d, tests_passed_q, tests_failed_d, tests_failed_q;
    logic        exit_valid_d, exit_valid_q, stdout_valid_d, stdout_valid_q;
    logic [31:0] exit_value_d, exit_value_q;
    logic [7:0]  stdout_char_d, stdout_char_q;

    assign core_fetch_enable_o = fetch_enable_i;
    assign boot_addr_o         = BOOT_ADDR;
    assign dm_halt_addr_o      = DM_HALTADDRESS;
    assign instr_gnt_o         = instr_req_i;
    assign data_gnt_o          = data_req_i;

    // Word-aligned RAM index; bits above RAM_ADDR_WIDTH only matter for MMIO.
    assign instr_idx        = {instr_addr_i[RAM_ADDR_WIDTH-1:2], 2'b00};
    assign data_idx         = {data_addr_i[RAM_ADDR_WIDTH-1:2], 2'b00};
    assign unused_addr_bits = ^{instr_addr_i[31:RAM_ADDR_WIDTH], instr_addr_i[1:0]};

    assign is_stdout = (data_addr_i == ADDR_STDOUT);
    assign is_tohost = (data_addr_i == ADDR_TOHOST);
    assign is_exit   = (data_addr_i == ADDR_EXIT);
    assign is_mmio   = is_stdout | is_tohost | is_exit;
    assign data_wr   = data_req_i & data_we_i;
    // Requests accepted during reset get no response, so they must not write either.
    assign ram_we    = data_wr & ~is_mmio & ~rst_i;

    cv32e40p_tb_subsys_ram #(.ADDR_WIDTH(RAM_ADDR_WIDTH)) ram_i (
        .clk_i        (clk_i),
        .instr_addr_i (instr_idx),
        .instr_word_o (instr_word),
        .data_addr_i  (data_idx),
        .data_we_i    (ram_we),
        .data_be_i    (data_be_i),
        .data_wdata_i (data_wdata_i),
        .data_word_o  (data_word)
    );

    always_comb begin
        instr_rvalid_d = instr_req_i;
        instr_rdata_d  = instr_req_i ? instr_word : 32'h0;
        data_rvalid_d  = data_req_i;
        // Writes and MMIO reads answer with zero.
        data_rdata_d   = (data_req_i && !data_we_i && !is_mmio) ? data_word : 32'h0;
        stdout_valid_d = data_wr & is_stdout;
        stdout_char_d  = stdout_valid_d ? data_wdata_i[7:0] : stdout_char_q;
        tests_passed_d = data_wr & is_tohost & (data_wdata_i == TOHOST_PASS);
        tests_failed_d = data_wr & is_tohost & (data_wdata_i == TOHOST_FAIL);
        exit_valid_d   = data_wr & is_exit;
        exit_value_d   = exit_valid_d ? data_wdata_i : exit_value_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_rvalid_q <= 1'b0;
            instr_rdata_q  <= 32'h0;
            data_rvalid_q  <= 1'b0;
            data_rdata_q   <= 32'h0;
            tests_passed_q <= 1'b0;
            tests_failed_q <= 1'b0;
            exit_valid_q   <= 1'b0;
            exit_value_q   <= 32'h0;
            stdout_valid_q <= 1'b0;
            stdout_char_q  <= 8'h0;
        end else begin
            instr_rvalid_q <= instr_rvalid_d;
            instr_rdata_q  <= instr_rdata_d;
            data_rvalid_q  <= data_rvalid_d;
            data_rdata_q   <= data_rdata_d;
            tests_passed_q <= tests_passed_d;
            tests_failed_q <= tests_failed_d;
            exit_valid_q   <= exit_valid_d;
            exit_value_q   <= exit_value_d;
            stdout_valid_q <= stdout_valid_d;
            stdout_char_q  <= stdout_char_d;
        end
    end

`ifdef STDOUT_PRINT_EN
    // Printed on the edge that raises stdout_valid_o.
    always_ff @(posedge clk_i) begin
        if (stdout_valid_d && !rst_i) $write("%c", data_wdata_i[7:0]);
    end
`endif

    assign instr_rvalid_o = instr_rvalid_q;
    assign instr_rdata_o  = instr_rdata_q;
    assign data_rvalid_o  = data_rvalid_q;
    assign data_rdata_o   = data_rdata_q;
    assign tests_passed_o = tests_passed_q;
    assign tests_failed_o = tests_failed_q;
    assign exit_valid_o   = exit_valid_q;
    assign exit_value_o   = exit_value_q;
    assign stdout_valid_o = stdout_valid_q;
    assign stdout_char_o  = stdout_char_q;
endmodule

// File: tb/tb_cv32e40p_tb_subsys.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_tb_subsys
//   Directed + randomized bench for cv32e40p_tb_subsys. A word-level model
//   (associative array keyed by word index) predicts RAM reads; MMIO events
//   are predicted from the address/data rules. Every comparison is an
//   immediate assertion.
// -----------------------------------------------------------------------------
module tb_cv32e40p_tb_subsys;
    localparam logic [31:0] A_STDOUT = 32'h1000_0000;
    localparam logic [31:0] A_TOHOST = 32'h2000_0000;
    localparam logic [31:0] A_EXIT   = 32'h2000_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_enable = 1'b0;
    logic        core_fetch_enable;
    logic [31:0] boot_addr, dm_halt_addr;
    logic        instr_req = 1'b0;
    logic [31:0] instr_addr = 32'h0;
    logic        instr_gnt, instr_rvalid;
    logic [31:0] instr_rdata;
    logic        data_req = 1'b0;
    logic [31:0] data_addr = 32'h0;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = 4'h0;
    logic [31:0] data_wdata = 32'h0;
    logic        data_gnt, data_rvalid;
    logic [31:0] data_rdata;
    logic        tests_passed, tests_failed, exit_valid, stdout_valid;
    logic [31:0] exit_value;
    logic [7:0]  stdout_char;

    int vectors = 0;
    int miscompares = 0;

    // Reference state
    logic [31:0] model_mem [int unsigned];
    logic [31:0] exp_exit_value = 32'h0;
    logic [7:0]  exp_char = 8'h0;

    cv32e40p_tb_subsys dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .fetch_enable_i      (fetch_enable),
        .core_fetch_enable_o (core_fetch_enable),
        .boot_addr_o         (boot_addr),
        .dm_halt_addr_o      (dm_halt_addr),
        .instr_req_i         (instr_req),
        .instr_addr_i        (instr_addr),
        .instr_gnt_o         (instr_gnt),
        .instr_rvalid_o      (instr_rvalid),
        .instr_rdata_o       (instr_rdata),
        .data_req_i          (data_req),
        .data_addr_i         (data_addr),
        .data_we_i           (data_we),
        .data_be_i           (data_be),
        .data_wdata_i        (data_wdata),
        .data_gnt_o          (data_gnt),
        .data_rvalid_o       (data_rvalid),
        .data_rdata_o        (data_rdata),
        .tests_passed_o      (tests_passed),
        .tests_failed_o      (tests_failed),
        .exit_valid_o        (exit_valid),
        .exit_value_o        (exit_value),
        .stdout_valid_o      (stdout_valid),
        .stdout_char_o       (stdout_char)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned word_key(input logic [31:0] addr);
        return int'(addr[21:2]);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        if (model_mem.exists(word_key(addr))) return model_mem[word_key(addr)];
        return 32'h0;
    endfunction

    function automatic bit is_mmio(input logic [31:0] addr);
        return (addr == A_STDOUT) || (addr == A_TOHOST) || (addr == A_EXIT);
    endfunction

    // Apply a write to the model: byte merge into RAM, or MMIO side effects.
    task automatic model_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
        logic [31:0] w;
        if (addr == A_STDOUT) exp_char = wdata[7:0];
        else if (addr == A_EXIT) exp_exit_value = wdata;
        else if (!is_mmio(addr)) begin
            w = model_read(addr);
            for (int b = 0; b < 4; b++)
                if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
            model_mem[word_key(addr)] = w;
        end
    endtask

    // One data transaction: grant, response one cycle later, one idle cycle.
    task automatic data_op(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input string tag);
        logic [31:0] exp_rdata;
        logic [3:0]  exp_pulses;   // {pass, fail, exit, stdout}
        exp_rdata  = (we || is_mmio(addr)) ? 32'h0 : model_read(addr);
        exp_pulses = {we && addr == A_TOHOST && wdata == 32'd123456789,
                      we && addr == A_TOHOST && wdata == 32'd1,
                      we && addr == A_EXIT,
                      we && addr == A_STDOUT};
        if (we) model_write(addr, be, wdata);
        @(negedge clk);
        data_req = 1'b1; data_we = we; data_addr = addr; data_be = be; data_wdata = wdata;
        #1 check({tag, ".gnt"}, 32'(data_gnt), 32'd1);
        @(posedge clk);
        #1 data_req = 1'b0; data_we = 1'b0;
        check({tag, ".rvalid"}, 32'(data_rvalid), 32'd1);
        check({tag, ".rdata"}, data_rdata, exp_rdata);
        check({tag, ".pulses"}, 32'({tests_passed, tests_failed, exit_valid, stdout_valid}), 32'(exp_pulses));
        check({tag, ".exit_value"}, exit_value, exp_exit_value);
        check({tag, ".stdout_char"}, 32'(stdout_char), 32'(exp_char));
        @(posedge clk);
        #1 check({tag, ".idle"}, 32'({data_rvalid, tests_passed, tests_failed, exit_valid, stdout_valid}), 32'd0);
    endtask

    task automatic fetch(input logic [31:0] addr, input string tag);
        logic [31:0] exp_word;
        exp_word = model_read(addr);
        @(negedge clk);
        instr_req = 1'b1; instr_addr = addr;
        #1 check({tag, ".gnt"}, 32'(instr_gnt), 32'd1);
        @(posedge clk);
        #1 instr_req = 1'b0;
        check({tag, ".rvalid"}, 32'(instr_rvalid), 32'd1);
        check({tag, ".rdata"}, instr_rdata, exp_word);
        @(posedge clk);
        #1 check({tag, ".idle"}, 32'(instr_rvalid), 32'd0);
    endtask

    // Fetch and full-word data write hit the same word in the same cycle.
    task automatic collide(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] old_word;
        old_word = model_read(addr);
        model_write(addr, 4'hF, wdata);
        @(negedge clk);
        instr_req = 1'b1; instr_addr = addr;
        data_req = 1'b1; data_we = 1'b1; data_addr = addr; data_be = 4'hF; data_wdata = wdata;
        @(posedge clk);
        #1 instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        check("collide.instr_rvalid", 32'(instr_rvalid), 32'd1);
        check("collide.instr_old", instr_rdata, old_word);
        check("collide.data_rvalid", 32'(data_rvalid), 32'd1);
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] addr, val;
        int sel;

        // Reset
        #1 rst = 1'b1;
        #2;
        check("rst.rvalids", 32'({instr_rvalid, data_rvalid}), 32'd0);
        check("rst.rdata", instr_rdata | data_rdata, 32'd0);
        check("rst.pulses", 32'({tests_passed, tests_failed, exit_valid, stdout_valid}), 32'd0);
        check("rst.exit_value", exit_value, 32'd0);
        check("rst.stdout_char", 32'(stdout_char), 32'd0);
        check("const.boot_addr", boot_addr, 32'h180);
        check("const.dm_halt", dm_halt_addr, 32'h1A110800);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Fetch-enable pass-through
        fetch_enable = 1'b1;
        #1 check("fetch_en.hi", 32'(core_fetch_enable), 32'd1);
        fetch_enable = 1'b0;
        #1 check("fetch_en.lo", 32'(core_fetch_enable), 32'd0);

        // Boot instruction
        data_op(1'b1, 32'h180, 4'hF, 32'h0000_0013, "load_boot");
        fetch(32'h180, "fetch_boot");

        // Partial byte write
        data_op(1'b1, 32'h100, 4'hF, 32'h0, "clear_100");
        data_op(1'b1, 32'h100, 4'b0101, 32'hAABB_CCDD, "be_write");
        data_op(1'b0, 32'h100, 4'hF, 32'h0, "be_read");
        check("be_read.const", model_read(32'h100), 32'h00BB_00DD);

        // MMIO events and MMIO reads
        data_op(1'b1, A_TOHOST, 4'hF, 32'd123456789, "pass");
        data_op(1'b1, A_TOHOST, 4'hF, 32'd1, "fail");
        data_op(1'b1, A_TOHOST, 4'hF, 32'd7, "tohost_other");
        data_op(1'b1, A_EXIT, 4'hF, 32'd3, "exit3");
        data_op(1'b1, A_STDOUT, 4'hF, 32'h41, "stdout_A");
        data_op(1'b0, A_EXIT, 4'hF, 32'h0, "mmio_read");
        check("exit_hold", exit_value, 32'd3);

        // Same-word collision
        collide(32'h180, 32'hDEAD_BEEF);
        fetch(32'h180, "fetch_after_collide");

        // Randomized region 0x1000..0x103C, with random upper and low address bits
        for (int w = 0; w < 16; w++)
            data_op(1'b1, 32'h1000 + 32'(w * 4), 4'hF, $urandom, "init");
        for (int n = 0; n < 80; n++) begin
            addr = ($urandom & 32'hFFC0_0000) | 32'h1000 | (32'($urandom_range(0, 15)) << 2)
                   | 32'($urandom_range(0, 3));
            sel = $urandom_range(0, 6);
            case (sel)
                0, 1: data_op(1'b1, addr, 4'($urandom_range(0, 15)), $urandom, "rnd_wr");
                2:    data_op(1'b0, addr, 4'hF, 32'h0, "rnd_rd");
                3:    fetch(addr, "rnd_fetch");
                4:    data_op(1'b1, A_STDOUT, 4'hF, $urandom, "rnd_stdout");
                5: begin
                    case ($urandom_range(0, 2))
                        0: val = 32'd123456789;
                        1: val = 32'd1;
                        default: val = $urandom;
                    endcase
                    data_op(1'b1, A_TOHOST, 4'hF, val, "rnd_tohost");
                end
                default: data_op(1'b1, A_EXIT, 4'hF, $urandom, "rnd_exit");
            endcase
        end

        // Asynchronous reset while responses/pulses are high
        data_op(1'b1, 32'h200, 4'hF, 32'h1234_5678, "pre_rst");
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b1; data_addr = A_EXIT; data_be = 4'hF; data_wdata = 32'd5;
        @(posedge clk);
        #1 data_req = 1'b0; data_we = 1'b0;
        check("arst.pre_rvalid", 32'({data_rvalid, exit_valid}), 32'd3);
        #1 rst = 1'b1;
        #1 check("arst.drop", 32'({data_rvalid, exit_valid}), 32'd0);
        check("arst.exit_value", exit_value, 32'd0);
        check("arst.stdout_char", 32'(stdout_char), 32'd0);
        exp_exit_value = 32'h0;
        exp_char = 8'h0;
        // Request accepted while reset is held: no response
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b1; data_addr = A_EXIT; data_wdata = 32'd9;
        @(posedge clk);
        #1 check("rst_req.none", 32'({data_rvalid, exit_valid}), 32'd0);
        @(negedge clk);
        data_req = 1'b0; data_we = 1'b0; rst = 1'b0;
        @(posedge clk);
        #1 check("rst_req.after", 32'({data_rvalid, exit_valid}), 32'd0);
        check("rst_req.exit_value", exit_value, 32'd0);
        data_op(1'b0, 32'h200, 4'hF, 32'h0, "ram_kept");
        fetch(32'h180, "ram_kept_fetch");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cv32e40p_tb_subsys.md
Name: cv32e40p_tb_subsys

Overview:
Simulation subsystem that provides program memory and testbench MMIO to an external CV32E40P-style core. It exposes an instruction fetch port and a data port, both OBI-style, backed by one dual-port byte RAM. Data-port stores to fixed MMIO addresses raise pass, fail, exit and stdout events, which the top-level bench uses to end the simulation.

Parameters:
INSTR_RDATA_WIDTH, 32, instruction read width; only 32 is legal.
RAM_ADDR_WIDTH, 22, byte address bits of the RAM (4 MiB).
BOOT_ADDR, 32'h180, value driven on boot_addr_o.
DM_HALTADDRESS, 32'h1A110800, value driven on dm_halt_addr_o.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  asynchronous reset, active-high.
fetch_enable_i  in  1  forwarded combinationally to core_fetch_enable_o.
core_fetch_enable_o  out  1  fetch enable to the core.
boot_addr_o  out  32  constant BOOT_ADDR.
dm_halt_addr_o  out  32  constant DM_HALTADDRESS.
instr_req_i  in  1  instruction request.
instr_addr_i  in  32  instruction byte address.
instr_gnt_o  out  1  instruction grant.
instr_rvalid_o  out  1  instruction response valid.
instr_rdata_o  out  32  instruction word.
data_req_i  in  1  data request.
data_addr_i  in  32  data byte address.
data_we_i  in  1  1 = write.
data_be_i  in  4  byte enables.
data_wdata_i  in  32  write data.
data_gnt_o  out  1  data grant.
data_rvalid_o  out  1  data response valid.
data_rdata_o  out  32  data read word.
tests_passed_o  out  1  pass pulse.
tests_failed_o  out  1  fail pulse.
exit_valid_o  out  1  exit pulse.
exit_value_o  out  32  exit code.
stdout_valid_o  out  1  character-written pulse.
stdout_char_o  out  8  character.

Behaviour:
- RAM: little-endian byte array `mem` of depth 2**RAM_ADDR_WIDTH, reachable at hierarchical path ram_i.dp_ram_i.mem so the bench can load it with $readmemh. RAM contents are not cleared by reset.
- Address mapping: RAM index = addr[RAM_ADDR_WIDTH-1:0] with the low 2 bits forced to 0 (word aligned). Upper address bits are ignored except for the MMIO decode below.
- Grant: gnt_o = req_i on both ports, combinationally; there are no stalls. A request is accepted on any cycle where req and gnt are both 1.
- Response: rvalid is asserted exactly one cycle after acceptance. rdata is registered and valid in the same cycle as rvalid.
- Writes return rvalid with rdata = 0. Reads from any MMIO address return 0.
- Data writes to RAM update only the bytes whose data_be_i bit is 1.
- If both ports touch the same word in the same cycle, the instruction port reads the old value.
- MMIO decode (data port writes only). An MMIO write does not modify RAM:
  - 32'h1000_0000: stdout_valid_o = 1 for one cycle, stdout_char_o = wdata[7:0].
  - 32'h2000_0000 with wdata == 123456789: tests_passed_o = 1 for one cycle.
  - 32'h2000_0000 with wdata == 1: tests_failed_o = 1 for one cycle.
  - 32'h2000_0000 with any other wdata: ignored.
  - 32'h2000_0004: exit_valid_o = 1 for one cycle, exit_value_o = wdata.
- Timing: every MMIO output is registered and rises in the cycle after acceptance, alongside data_rvalid_o. exit_value_o and stdout_char_o hold their value until the next write to the same address.
- Reset: every output register clears to 0 (rvalid, rdata, pass, fail, exit_valid, exit_value, stdout_valid, stdout_char). If a request is accepted in a cycle where rst_i is asserted, that request produces no response.
- Elaboration: INSTR_RDATA_WIDTH != 32 triggers $fatal.

Optional Feature:
STDOUT_PRINT_EN:
- Defined: every stdout write additionally calls $write("%c", char) in the same cycle that stdout_valid_o rises.
- Undefined: no simulator output is printed; the port behaviour is unchanged.

Test Plan:
- Load mem with 0x00000013 at 0x180; instr_req_i=1, instr_addr_i=0x180 -> gnt in the same cycle; next cycle instr_rvalid_o=1, instr_rdata_o=0x00000013.
- Data write 0xAABBCCDD to 0x100 with be=4'b0101, then read 0x100 (prior contents 0) -> read data 0x00BB00DD.
- Data write 123456789 to 0x2000_0000 -> tests_passed_o=1 for exactly one cycle, one cycle after acceptance. Write 1 -> tests_failed_o pulses once. Write 7 -> no pulse.
- Data write 3 to 0x2000_0004 -> exit_valid_o pulses once, exit_value_o=3 and holds.
- Write 0x41 to 0x1000_0000 -> stdout_valid_o pulse, stdout_char_o=0x41; with STDOUT_PRINT_EN the simulator prints "A".
- Assert rst_i asynchronously while rvalid and exit_valid_o are 1 -> both drop to 0 immediately; RAM contents are preserved.
